// File: rtl/mem_map_if.sv
// Bus bundle between the core load/store path, mem_map_controller and the
// decoded slaves (ROM, data RAM, stack RAM, MMIO).
//
// CPU side   : cpu_req/cpu_we/cpu_addr/cpu_wdata in, cpu_ready/cpu_err/cpu_rdata out.
// Slave side : slv_sel/slv_we/slv_addr/slv_wdata out, slv_rdata/slv_ready in.
//
// Modports:
//   master - the environment (CPU plus slaves) driving requests and slave responses.
//   slave  - the controller view.
interface mem_map_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned N_REGIONS  = 4
);
    logic                            cpu_req;
    logic                            cpu_we;
    logic [ADDR_WIDTH-1:0]           cpu_addr;
    logic [DATA_WIDTH-1:0]           cpu_wdata;
    logic                            cpu_ready;
    logic                            cpu_err;
    logic [DATA_WIDTH-1:0]           cpu_rdata;
    logic [N_REGIONS-1:0]            slv_sel;
    logic [N_REGIONS-1:0]            slv_we;
    logic [ADDR_WIDTH-1:0]           slv_addr;
    logic [DATA_WIDTH-1:0]           slv_wdata;
    logic [N_REGIONS*DATA_WIDTH-1:0] slv_rdata;
    logic [N_REGIONS-1:0]            slv_ready;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_rdata, slv_ready,
        input  cpu_ready, cpu_err, cpu_rdata, slv_sel, slv_we, slv_addr, slv_wdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_rdata, slv_ready,
        output cpu_ready, cpu_err, cpu_rdata, slv_sel, slv_we, slv_addr, slv_wdata
    );
endinterface

// File: rtl/mem_map_controller.sv
// Memory map controller: decodes CPU byte addresses into N_REGIONS regions,
// strobes exactly one slave with a region-local word index and returns the
// result over a request/ready handshake with timeout and error reporting.
//
// Ports:
//   clk        - system clock
//   rst_n      - asynchronous active-low reset
//   bus        - mem_map_if.slave (CPU request/response and slave strobes)
//   err_addr_o - faulting byte address      (only with MEM_MAP_ERR_CAPTURE_EN)
//   err_code_o - 1 misaligned, 2 unmapped,
//                3 read-only write, 4 timeout (only with MEM_MAP_ERR_CAPTURE_EN)
//
// Optional feature macro: MEM_MAP_ERR_CAPTURE_EN (sticky error address/code capture).
module mem_map_controller #(
    parameter int unsigned                      DATA_WIDTH     = 32,
    parameter int unsigned                      ADDR_WIDTH     = 32,
    parameter int unsigned                      N_REGIONS      = 4,
    parameter logic [N_REGIONS*ADDR_WIDTH-1:0]  REGION_BASE    = {32'h10000000, 32'h7FFFE000,
                                                                  32'h10010000, 32'h00400000},
    parameter logic [N_REGIONS*ADDR_WIDTH-1:0]  REGION_SIZE    = {32'h100, 32'h2000,
                                                                  32'h1000, 32'h1000},
    parameter logic [N_REGIONS-1:0]             RO_MASK        = 4'b0001,
    parameter int unsigned                      TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_map_if.slave              bus
`ifdef MEM_MAP_ERR_CAPTURE_EN
    ,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    output logic [2:0]            err_code_o
`endif
);

    localparam int unsigned IdxW = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StResp   = 2'd2;

    localparam logic [2:0] ErrNone     = 3'd0;
    localparam logic [2:0] ErrMisalign = 3'd1;
    localparam logic [2:0] ErrUnmapped = 3'd2;
    localparam logic [2:0] ErrReadOnly = 3'd3;
`ifdef MEM_MAP_ERR_CAPTURE_EN
    localparam logic [2:0] ErrTimeout  = 3'd4;
`endif

    logic [1:0]            state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] slv_addr_q, slv_addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
`ifdef MEM_MAP_ERR_CAPTURE_EN
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic [2:0]            err_code_q, err_code_d;
`endif

    // Address decode. Bounds are compared one bit wider than the address so a
    // region ending at the top of the address space does not wrap to zero.
    logic                  hit;
    logic [IdxW-1:0]       hit_idx;
    logic [ADDR_WIDTH-1:0] hit_off;
    logic [ADDR_WIDTH:0]   lo_w, hi_w;
    logic [2:0]            dec_code;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_off = '0;
        lo_w    = '0;
        hi_w    = '0;
        // Walk from the highest index down so the lowest matching index wins.
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            lo_w = {1'b0, REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]};
            hi_w = lo_w + {1'b0, REGION_SIZE[i*ADDR_WIDTH +: ADDR_WIDTH]};
            if (({1'b0, bus.cpu_addr} >= lo_w) && ({1'b0, bus.cpu_addr} < hi_w)) begin
                hit     = 1'b1;
                hit_idx = IdxW'(i);
                hit_off = bus.cpu_addr - lo_w[ADDR_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        dec_code = ErrNone;
        if (bus.cpu_addr[1:0] != 2'b00) begin
            dec_code = ErrMisalign;
        end else if (!hit) begin
            dec_code = ErrUnmapped;
        end else if (bus.cpu_we && RO_MASK[hit_idx]) begin
            dec_code = ErrReadOnly;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        we_d       = we_q;
        slv_addr_d = slv_addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
`ifdef MEM_MAP_ERR_CAPTURE_EN
        addr_d     = addr_q;
        err_addr_d = err_addr_q;
        err_code_d = err_code_q;
`endif
        case (state_q)
            StIdle: begin
                if (bus.cpu_req) begin
                    if (dec_code == ErrNone) begin
                        idx_d      = hit_idx;
                        we_d       = bus.cpu_we;
                        slv_addr_d = hit_off >> 2;
                        wdata_d    = bus.cpu_wdata;
                        cnt_d      = '0;
                        err_d      = 1'b0;
                        state_d    = StAccess;
`ifdef MEM_MAP_ERR_CAPTURE_EN
                        addr_d     = bus.cpu_addr;
`endif
                    end else begin
                        err_d   = 1'b1;
                        state_d = StResp;
`ifdef MEM_MAP_ERR_CAPTURE_EN
                        err_addr_d = bus.cpu_addr;
                        err_code_d = dec_code;
`endif
                    end
                end
            end
            StAccess: begin
                if (bus.slv_ready[idx_q]) begin
                    if (!we_q) begin
                        rdata_d = bus.slv_rdata[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
                    end
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    // This was the TIMEOUT_CYCLES-th access cycle without ready.
                    err_d   = 1'b1;
                    state_d = StResp;
`ifdef MEM_MAP_ERR_CAPTURE_EN
                    err_addr_d = addr_q;
                    err_code_d = ErrTimeout;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            we_q       <= 1'b0;
            slv_addr_q <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
`ifdef MEM_MAP_ERR_CAPTURE_EN
            addr_q     <= '0;
            err_addr_q <= '0;
            err_code_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            we_q       <= we_d;
            slv_addr_q <= slv_addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
`ifdef MEM_MAP_ERR_CAPTURE_EN
            addr_q     <= addr_d;
            err_addr_q <= err_addr_d;
            err_code_q <= err_code_d;
`endif
        end
    end

    // Strobes decode straight from the state register so an asynchronous
    // reset drops them without waiting for a clock edge.
    logic [N_REGIONS-1:0] sel_onehot;

    always_comb begin
        sel_onehot = '0;
        if (state_q == StAccess) begin
            sel_onehot[idx_q] = 1'b1;
        end
    end

    assign bus.slv_sel   = sel_onehot;
    assign bus.slv_we    = we_q ? sel_onehot : '0;
    assign bus.slv_addr  = slv_addr_q;
    assign bus.slv_wdata = wdata_q;
    assign bus.cpu_ready = (state_q == StResp);
    assign bus.cpu_err   = (state_q == StResp) && err_q;
    assign bus.cpu_rdata = rdata_q;

`ifdef MEM_MAP_ERR_CAPTURE_EN
    assign err_addr_o = err_addr_q;
    assign err_code_o = err_code_q;
`endif

endmodule

// File: tb/tb_mem_map_controller.sv
// Self-checking bench for mem_map_controller: directed cases plus randomized
// accesses checked against an arithmetic model of the memory map.
module tb_mem_map_controller;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned NR = 4;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_map_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_REGIONS(NR)) bus ();

`ifdef MEM_MAP_ERR_CAPTURE_EN
    logic [AW-1:0] err_addr;
    logic [2:0]    err_code;
`endif

    mem_map_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus)
`ifdef MEM_MAP_ERR_CAPTURE_EN
        ,
        .err_addr_o (err_addr),
        .err_code_o (err_code)
`endif
    );

    // Memory map as plain numbers.
    longint unsigned m_base [NR] = '{64'h0040_0000, 64'h1001_0000, 64'h7FFF_E000, 64'h1000_0000};
    longint unsigned m_size [NR] = '{64'h1000, 64'h1000, 64'h2000, 64'h100};
    bit              m_ro   [NR] = '{1'b1, 1'b0, 1'b0, 1'b0};

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] exp_err_addr = '0;
    logic [2:0]  exp_err_code = '0;

    function automatic int model_region(input logic [31:0] a);
        for (int i = 0; i < int'(NR); i++) begin
            if (longint'(a) >= m_base[i] && longint'(a) < m_base[i] + m_size[i]) return i;
        end
        return -1;
    endfunction

    function automatic int model_code(input logic we, input logic [31:0] a);
        int r;
        if (a % 4 != 0) return 1;
        r = model_region(a);
        if (r < 0) return 2;
        if (we && m_ro[r]) return 3;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_capture();
`ifdef MEM_MAP_ERR_CAPTURE_EN
        check("err_addr", err_addr, exp_err_addr);
        check("err_code", err_code, exp_err_code);
`endif
    endtask

    // One access starting at a negedge. delay = ACCESS cycle in which the
    // selected slave answers; outside 1..TO the slave never answers.
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input int delay, input logic [31:0] rd_val);
        int          code;
        int          r;
        int          resp_c;
        logic [3:0]  rdy;
        code = model_code(we, addr);
        r    = model_region(addr);
        if (code != 0) resp_c = 1;
        else if (delay >= 1 && delay <= int'(TO)) resp_c = delay + 1;
        else begin
            resp_c = TO + 1;
            code   = 4;
        end
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        bus.slv_ready = '0;
        for (int c = 1; c <= resp_c; c++) begin
            @(negedge clk);
            check("cpu_ready", bus.cpu_ready, 64'(c == resp_c));
            if (c < resp_c) begin
                check("slv_sel", bus.slv_sel, 64'(1) << r);
                check("slv_we", bus.slv_we, we ? (64'(1) << r) : 64'(0));
                check("slv_addr", bus.slv_addr, (longint'(addr) - m_base[r]) >> 2);
                check("slv_wdata", bus.slv_wdata, wdata);
                // Other slaves chatter on ready/rdata; only slave r matters.
                rdy           = 4'($urandom);
                rdy[r]        = (c == delay);
                bus.slv_ready = rdy;
                bus.slv_rdata = {$urandom, $urandom, $urandom, $urandom};
                bus.slv_rdata[r*32 +: 32] = rd_val;
                if (c == delay && !we) exp_rdata = rd_val;
            end else begin
                check("cpu_err", bus.cpu_err, 64'(code != 0));
                check("resp_sel", bus.slv_sel, 0);
                check("cpu_rdata", bus.cpu_rdata, exp_rdata);
                if (code != 0) begin
                    exp_err_addr = addr;
                    exp_err_code = 3'(code);
                end
                check_capture();
                bus.cpu_req   = 1'b0;
                bus.slv_ready = '0;
            end
        end
        @(negedge clk);
        check("idle_ready", bus.cpu_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          r;
        int          d;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.slv_rdata = '0;
        bus.slv_ready = '0;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst_ready", bus.cpu_ready, 0);
        check("rst_err", bus.cpu_err, 0);
        check("rst_rdata", bus.cpu_rdata, 0);
        check("rst_sel", bus.slv_sel, 0);
        check("rst_we", bus.slv_we, 0);
        check("rst_addr", bus.slv_addr, 0);
        check("rst_wdata", bus.slv_wdata, 0);
        check_capture();
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        run_access(1'b0, 32'h0040_0008, 32'h0, 1, 32'hDEAD_BEEF);
        run_access(1'b1, 32'h7FFF_EEFC, 32'h1234_5678, 3, 32'hAAAA_5555);
        run_access(1'b0, 32'h0040_0002, 32'h0, 1, 32'h0);
        run_access(1'b0, 32'h2000_0000, 32'h0, 1, 32'h0);
        run_access(1'b1, 32'h0040_0000, 32'h5555_AAAA, 1, 32'h0);
        run_access(1'b0, 32'h1001_0000, 32'h0, 0, 32'h0);
        run_access(1'b0, 32'h0040_0FFC, 32'h0, 2, 32'hCAFE_F00D);
        run_access(1'b0, 32'h0040_1000, 32'h0, 1, 32'h0);
        run_access(1'b0, 32'h1000_00FC, 32'h0, TO, 32'h0BAD_CAFE);

        // Request held through RESP is taken again after one IDLE cycle.
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'h2000_0000;
        @(negedge clk);
        check("hold_resp1", {bus.cpu_ready, bus.cpu_err}, 2'b11);
        @(negedge clk);
        check("hold_idle", bus.cpu_ready, 0);
        @(negedge clk);
        check("hold_resp2", {bus.cpu_ready, bus.cpu_err}, 2'b11);
        bus.cpu_req  = 1'b0;
        exp_err_addr = 32'h2000_0000;
        exp_err_code = 3'd2;
        @(negedge clk);
        check("hold_done", bus.cpu_ready, 0);

        // Reset in the middle of a region 3 read.
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 32'h1000_0010;
        bus.slv_ready = '0;
        @(negedge clk);
        check("pre_rst_sel", bus.slv_sel, 4'b1000);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_sel", bus.slv_sel, 0);
        bus.cpu_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_no_ready", bus.cpu_ready, 0);
        end
        rst_n        = 1'b1;
        exp_rdata    = '0;
        exp_err_addr = '0;
        exp_err_code = '0;
        @(negedge clk);
        check("post_rst_ready", bus.cpu_ready, 0);
        check("post_rst_sel", bus.slv_sel, 0);
        check_capture();
        run_access(1'b0, 32'h1000_0020, 32'h0, 2, 32'h1357_9BDF);

        // Randomized accesses.
        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, NR - 1));
            case ($urandom_range(0, 5))
                0, 1, 2: a = 32'(m_base[r] + 4 * longint'($urandom_range(0, 32'(m_size[r] / 4 - 1))));
                3:       a = 32'(m_base[r] + m_size[r] - (($urandom_range(0, 1) == 0) ? 4 : 0));
                4:       a = $urandom;
                default: a = 32'(m_base[r] + longint'($urandom_range(0, 32'(m_size[r] - 1))));
            endcase
            if ($urandom_range(0, 3) == 0) d = int'($urandom_range(1, TO + 2));
            else d = int'($urandom_range(1, 4));
            run_access(1'($urandom), a, $urandom, d, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
